// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder: a start handshake carrying
// the target value and mode, and a done handshake carrying the encoded field.
interface imm_encoder_if;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  ImmSrc;
    logic [31:0] value;
    logic        done_valid;
    logic        done_ready;
    logic [23:0] Instruction;
    logic        fits;

    modport master (
        output start_valid, ImmSrc, value, done_ready,
        input  start_ready, done_valid, Instruction, fits
    );

    modport slave (
        input  start_valid, ImmSrc, value, done_ready,
        output start_ready, done_valid, Instruction, fits
    );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: inverse of the ARM-style immediate extender, including a
// multi-cycle search for the rotated 8-bit immediate form (mode 11).
module imm_encoder #(
    parameter int ROT_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_encoder_if.slave bus
);

    if (ROT_PER_CYCLE != 1 && ROT_PER_CYCLE != 2 && ROT_PER_CYCLE != 4 &&
        ROT_PER_CYCLE != 8 && ROT_PER_CYCLE != 16) begin : g_bad_rot
        $error("imm_encoder: ROT_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [3:0] LAST_B = 4'(16 / ROT_PER_CYCLE - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, state_d;
    logic [3:0]  batch, batch_d;
    logic [31:0] value_q;
    logic [23:0] instr_q, instr_d;
    logic        fits_q, fits_d;
    logic        dv_q, dv_d;

    logic        fast_fits;
    logic [23:0] fast_instr;
    logic        hit;
    logic [3:0]  hit_r;
    logic [7:0]  hit_imm;
    logic [3:0]  cand_r;
    logic [31:0] cand_rot;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] d;
        d = {x, x} << s;
        return d[63:32];
    endfunction

    assign bus.start_ready = (state == IDLE);
    assign bus.done_valid  = dv_q;
    assign bus.Instruction = instr_q;
    assign bus.fits        = fits_q;

    // Direct modes resolve from the live inputs at the accept edge.
    always_comb begin
        fast_fits  = 1'b0;
        fast_instr = '0;
        case (bus.ImmSrc)
            2'b00: begin
                fast_fits  = (bus.value[31:8] == '0);
                fast_instr = {16'b0, bus.value[7:0]};
            end
            2'b01: begin
                fast_fits  = (bus.value[31:12] == '0);
                fast_instr = {12'b0, bus.value[11:0]};
            end
            2'b10: begin
                fast_fits  = (bus.value[1:0] == 2'b00) &&
                             (bus.value[31:26] == {6{bus.value[25]}});
                fast_instr = bus.value[25:2];
            end
            default: ;
        endcase
    end

    // Descending scan so the lowest matching rotation in the batch wins.
    always_comb begin
        hit      = 1'b0;
        hit_r    = '0;
        hit_imm  = '0;
        cand_r   = '0;
        cand_rot = '0;
        for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
            cand_r   = 4'(int'(batch) * ROT_PER_CYCLE + i);
            cand_rot = rol32(value_q, {cand_r, 1'b0});
            if (cand_rot[31:8] == '0) begin
                hit     = 1'b1;
                hit_r   = cand_r;
                hit_imm = cand_rot[7:0];
            end
        end
    end

    always_comb begin
        state_d = state;
        batch_d = batch;
        instr_d = instr_q;
        fits_d  = fits_q;
        dv_d    = dv_q;
        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    if (bus.ImmSrc == 2'b11) begin
                        state_d = SEARCH;
                        batch_d = '0;
                    end else begin
                        state_d = DONE;
                        dv_d    = 1'b1;
                        fits_d  = fast_fits;
                        instr_d = fast_fits ? fast_instr : '0;
                    end
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = DONE;
                    dv_d    = 1'b1;
                    fits_d  = 1'b1;
                    instr_d = {12'b0, hit_r, hit_imm};
                end else if (batch == LAST_B) begin
                    state_d = DONE;
                    dv_d    = 1'b1;
                    fits_d  = 1'b0;
                    instr_d = '0;
                end else begin
                    batch_d = batch + 4'd1;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                    dv_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            batch   <= '0;
            instr_q <= '0;
            fits_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state   <= state_d;
            batch   <= batch_d;
            instr_q <= instr_d;
            fits_q  <= fits_d;
            dv_q    <= dv_d;
        end
    end

    // Search operand is pure data; only meaningful while in SEARCH.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start_valid && bus.ImmSrc == 2'b11)
            value_q <= bus.value;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, backpressure, async
// abort and a random round-trip sweep on N=1 and N=4 instances.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if bus1();
    imm_encoder_if bus4();

    imm_encoder #(.ROT_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    imm_encoder #(.ROT_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [23:0] instr;
        logic        fits;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        int t;
        t = s % 32;
        if (t == 0) return x;
        return (x >> t) | (x << (32 - t));
    endfunction

    function automatic logic [31:0] extend(input logic [23:0] ins, input logic [1:0] src);
        case (src)
            2'b00:   return {24'b0, ins[7:0]};
            2'b01:   return {20'b0, ins[11:0]};
            2'b10:   return {{6{ins[23]}}, ins, 2'b00};
            default: return ror32({24'b0, ins[7:0]}, 2 * int'(ins[11:8]));
        endcase
    endfunction

    function automatic void model(input logic [1:0] src, input logic [31:0] v, input int n,
                                  output logic [23:0] ins, output logic f, output int lat);
        logic [31:0] c;
        ins = '0; f = 1'b0; lat = 1;
        case (src)
            2'b00: begin f = (v < 32'h100);  if (f) ins = {16'b0, v[7:0]}; end
            2'b01: begin f = (v < 32'h1000); if (f) ins = {12'b0, v[11:0]}; end
            2'b10: begin
                f = (v[1:0] == 2'b00) && ($signed(v) >= -32'sh0200_0000) &&
                    ($signed(v) < 32'sh0200_0000);
                if (f) ins = v[25:2];
            end
            default: begin
                lat = 16 / n;
                for (int r = 15; r >= 0; r--) begin
                    c = ror32(v, 32 - 2 * r);
                    if (c < 32'h100) begin
                        f = 1'b1; ins = {12'b0, 4'(r), c[7:0]}; lat = r / n + 1;
                    end
                end
            end
        endcase
    endfunction

    function automatic logic rd_dv(input int sel);
        return (sel == 4) ? bus4.done_valid : bus1.done_valid;
    endfunction
    function automatic logic rd_sr(input int sel);
        return (sel == 4) ? bus4.start_ready : bus1.start_ready;
    endfunction
    function automatic logic rd_fits(input int sel);
        return (sel == 4) ? bus4.fits : bus1.fits;
    endfunction
    function automatic logic [23:0] rd_instr(input int sel);
        return (sel == 4) ? bus4.Instruction : bus1.Instruction;
    endfunction

    task automatic set_start(input int sel, input logic sv, input logic [1:0] src, input logic [31:0] v);
        if (sel == 4) begin
            bus4.start_valid = sv; bus4.ImmSrc = src; bus4.value = v;
        end else begin
            bus1.start_valid = sv; bus1.ImmSrc = src; bus1.value = v;
        end
    endtask

    task automatic set_ready(input int sel, input logic dr);
        if (sel == 4) bus4.done_ready = dr;
        else          bus1.done_ready = dr;
    endtask

    task automatic run_req(input int sel, input logic [1:0] src, input logic [31:0] v,
                           input logic [23:0] e_instr, input logic e_fits, input int e_lat,
                           input string tag);
        exp_t e;
        int lat;
        @(negedge clk);
        total++;
        if (rd_sr(sel) !== 1'b1) begin
            bad++; $display("FAIL %s start_ready got=%0b want=1", tag, rd_sr(sel));
        end
        set_start(sel, 1'b1, src, v);
        e.instr = e_instr; e.fits = e_fits; e.lat = e_lat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        set_start(sel, 1'b0, src, v);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (rd_dv(sel) === 1'b1) begin lat = k; break; end
        end
        e = exp_q.pop_front();
        total++;
        if (lat == 0) begin
            bad++; $display("FAIL %s timeout no done_valid within 40 cycles want lat=%0d", tag, e.lat);
        end else begin
            total += 3;
            if (rd_instr(sel) !== e.instr) begin
                bad++; $display("FAIL %s instr v=%h got=%h want=%h", tag, v, rd_instr(sel), e.instr);
            end
            if (rd_fits(sel) !== e.fits) begin
                bad++; $display("FAIL %s fits v=%h got=%0b want=%0b", tag, v, rd_fits(sel), e.fits);
            end
            if (lat != e.lat) begin
                bad++; $display("FAIL %s latency v=%h got=%0d want=%0d", tag, v, lat, e.lat);
            end
            if (rd_fits(sel) === 1'b1) begin
                total++;
                if (extend(rd_instr(sel), src) !== v) begin
                    bad++; $display("FAIL %s roundtrip got=%h want=%h", tag, extend(rd_instr(sel), src), v);
                end
            end
            set_ready(sel, 1'b1);
            @(posedge clk); #1;
            set_ready(sel, 1'b0);
            total++;
            if (rd_dv(sel) !== 1'b0 || rd_sr(sel) !== 1'b1) begin
                bad++; $display("FAIL %s release dv=%0b sr=%0b want dv=0 sr=1", tag, rd_dv(sel), rd_sr(sel));
            end
        end
    endtask

    task automatic check_reset_vals(input int sel, input string tag);
        total++;
        if (rd_sr(sel) !== 1'b1 || rd_dv(sel) !== 1'b0 || rd_fits(sel) !== 1'b0 || rd_instr(sel) !== 24'h0) begin
            bad++;
            $display("FAIL %s sr=%0b dv=%0b fits=%0b instr=%h want sr=1 dv=0 fits=0 instr=000000",
                     tag, rd_sr(sel), rd_dv(sel), rd_fits(sel), rd_instr(sel));
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals(1, "reset_n1");
        check_reset_vals(4, "reset_n4");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_direct_modes();
        run_req(1, 2'b00, 32'h0000_00A5, 24'h0000A5, 1'b1, 1, "m00_a5");
        run_req(1, 2'b00, 32'h0000_0100, 24'h000000, 1'b0, 1, "m00_100");
        run_req(1, 2'b01, 32'h0000_0FFF, 24'h000FFF, 1'b1, 1, "m01_fff");
        run_req(1, 2'b10, 32'hFFFF_FFF8, 24'hFFFFFE, 1'b1, 1, "m10_neg8");
        run_req(1, 2'b10, 32'h0200_0000, 24'h000000, 1'b0, 1, "m10_range");
        run_req(1, 2'b10, 32'h0000_0006, 24'h000000, 1'b0, 1, "m10_misal");
    endtask

    task automatic test_rotated();
        run_req(1, 2'b11, 32'h0000_00FF, 24'h0000FF, 1'b1, 1,  "m11n1_ff");
        run_req(1, 2'b11, 32'hFF00_0000, 24'h0004FF, 1'b1, 5,  "m11n1_ff000000");
        run_req(1, 2'b11, 32'h0000_03FC, 24'h000FFF, 1'b1, 16, "m11n1_3fc");
        run_req(1, 2'b11, 32'h0000_0101, 24'h000000, 1'b0, 16, "m11n1_101");
        run_req(4, 2'b11, 32'hFF00_0000, 24'h0004FF, 1'b1, 2,  "m11n4_ff000000");
        run_req(4, 2'b11, 32'h0000_03FC, 24'h000FFF, 1'b1, 4,  "m11n4_3fc");
        run_req(4, 2'b11, 32'h0000_0101, 24'h000000, 1'b0, 4,  "m11n4_101");
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(negedge clk);
        set_start(1, 1'b1, 2'b00, 32'h0000_005A);
        e.instr = 24'h00005A; e.fits = 1'b1; e.lat = 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        set_start(1, 1'b1, 2'b00, 32'h0000_0033);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total++;
        if (bus1.done_valid !== 1'b1 || bus1.Instruction !== e.instr || bus1.fits !== e.fits) begin
            bad++; $display("FAIL bp_first dv=%0b instr=%h fits=%0b want dv=1 instr=%h fits=%0b",
                            bus1.done_valid, bus1.Instruction, bus1.fits, e.instr, e.fits);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus1.done_valid !== 1'b1 || bus1.Instruction !== 24'h00005A ||
                bus1.fits !== 1'b1 || bus1.start_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d dv=%0b instr=%h fits=%0b sr=%0b want dv=1 instr=00005a fits=1 sr=0",
                                c, bus1.done_valid, bus1.Instruction, bus1.fits, bus1.start_ready);
            end
        end
        e.instr = 24'h000033; e.fits = 1'b1; e.lat = 1;
        exp_q.push_back(e);
        set_ready(1, 1'b1);
        @(posedge clk); #1;
        set_ready(1, 1'b0);
        total++;
        if (bus1.start_ready !== 1'b1 || bus1.done_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release sr=%0b dv=%0b want sr=1 dv=0", bus1.start_ready, bus1.done_valid);
        end
        @(posedge clk); #1;
        set_start(1, 1'b0, 2'b00, 32'h0);
        total++;
        if (bus1.start_ready !== 1'b0) begin
            bad++; $display("FAIL bp_accept sr=%0b want=0", bus1.start_ready);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total++;
        if (bus1.done_valid !== 1'b1 || bus1.Instruction !== e.instr || bus1.fits !== e.fits) begin
            bad++; $display("FAIL bp_second dv=%0b instr=%h fits=%0b want dv=1 instr=%h fits=%0b",
                            bus1.done_valid, bus1.Instruction, bus1.fits, e.instr, e.fits);
        end
        set_ready(1, 1'b1);
        @(posedge clk); #1;
        set_ready(1, 1'b0);
    endtask

    task automatic test_reset_search();
        int seen;
        @(negedge clk);
        set_start(1, 1'b1, 2'b11, 32'h0000_0101);
        @(posedge clk); #1;
        set_start(1, 1'b0, 2'b11, 32'h0000_0101);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(1, "abort_async");
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus1.done_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL abort_no_done done_valid cycles got=%0d want=0", seen);
        end
        run_req(1, 2'b01, 32'h0000_0ABC, 24'h000ABC, 1'b1, 1, "m01_after_abort");
    endtask

    task automatic test_random();
        logic [31:0] v, t;
        logic [1:0]  src;
        logic [23:0] ei;
        logic        ef;
        int          el, sel;
        for (int i = 0; i < 1000; i++) begin
            sel = (i % 2 == 1) ? 4 : 1;
            src = 2'($urandom_range(0, 3));
            t = $urandom;
            case ($urandom_range(0, 3))
                0:       v = t;
                1:       v = ror32({24'b0, t[7:0]}, int'($urandom_range(0, 31)));
                2:       v = {20'b0, t[11:0]};
                default: begin
                    v = {{6{t[25]}}, t[25:0]};
                    if (t[31]) v[1:0] = 2'b00;
                end
            endcase
            model(src, v, sel, ei, ef, el);
            run_req(sel, src, v, ei, ef, el, "random");
        end
    endtask

    initial begin
        bus1.start_valid = 1'b0; bus1.ImmSrc = 2'b00; bus1.value = '0; bus1.done_ready = 1'b0;
        bus4.start_valid = 1'b0; bus4.ImmSrc = 2'b00; bus4.value = '0; bus4.done_ready = 1'b0;
        test_reset();
        test_direct_modes();
        test_rotated();
        test_backpressure();
        test_reset_search();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
